// File: rtl/chacha_block_core_if.sv
// chacha_block_core_if -- handshake bundle between the state-assembly
// logic (master) and the ChaCha block engine (slave).
//   in_valid/in_ready/in_state    : 512-bit input state, word i = [32i+31:32i]
//   out_valid/out_ready/out_state : 512-bit result, same word layout
//   busy                          : engine is holding a block (RUN or DONE)
interface chacha_block_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/chacha_block_core.sv
// chacha_block_core -- iterative ChaCha block function.
// Accepts a 512-bit state, runs ROUNDS rounds with PAR_QR quarter-rounds per
// clock, optionally adds the input state back (FEEDFORWARD) and holds the
// result until the downstream handshake.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, discards any in-flight block
//   bus : chacha_block_core_if.slave (in/out valid-ready, states, busy)

// One ChaCha quarter-round on x = {d,c,b,a}; y uses the same word order.
module chacha_qr (
    input  logic [3:0][31:0] x,
    output logic [3:0][31:0] y
);
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    logic [31:0] a, b, c, d;

    always_comb begin
        a = x[0]; b = x[1]; c = x[2]; d = x[3];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        y = {d, c, b, a};
    end
endmodule

module chacha_block_core #(
    parameter int ROUNDS      = 20,
    parameter int PAR_QR      = 4,
    parameter int FEEDFORWARD = 1
) (
    input  logic                clk,
    input  logic                rst,
    chacha_block_core_if.slave  bus
);
    localparam int N  = ROUNDS * 4 / PAR_QR;   // RUN cycles per block
    localparam int CW = $clog2(N + 1);
    // log2 of clock cycles per half-round
    localparam int LOG_GPC = (PAR_QR == 1) ? 2 : (PAR_QR == 2) ? 1 : 0;

    if (!((ROUNDS >= 2) && (ROUNDS % 2 == 0))) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and >= 2");
    end
    if (!((PAR_QR == 1) || (PAR_QR == 2) || (PAR_QR == 4))) begin : g_bad_par
        $error("chacha_block_core: PAR_QR must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state, state_n;
    logic   [CW-1:0]                 cnt;
    logic   [15:0][31:0]             work, save, work_n, result, out_reg;
    logic                            in_ready, out_valid, busy;
    logic                            last, diag;
    logic   [1:0]                    sub, grp_base;
    logic   [PAR_QR-1:0][3:0][3:0]   idx;
    logic   [PAR_QR-1:0][3:0][31:0]  qy_all;

    assign last = (cnt == CW'(N - 1));

    // cnt splits into {half-round, group slot}; the low LOG_GPC bits pick
    // which groups this cycle handles, bit LOG_GPC is the column/diag parity.
    assign diag     = cnt[LOG_GPC];
    assign sub      = cnt[1:0] & 2'((1 << LOG_GPC) - 1);
    assign grp_base = 2'(int'(sub) * PAR_QR);

    // Word indices per lane: row r of group g is word 4r + ((g + r*diag) mod 4).
    always_comb begin
        idx = '0;
        for (int l = 0; l < PAR_QR; l++) begin
            idx[l][0] = {2'd0, grp_base + 2'(l)};
            idx[l][1] = {2'd1, grp_base + 2'(l) + (diag ? 2'd1 : 2'd0)};
            idx[l][2] = {2'd2, grp_base + 2'(l) + (diag ? 2'd2 : 2'd0)};
            idx[l][3] = {2'd3, grp_base + 2'(l) + (diag ? 2'd3 : 2'd0)};
        end
    end

    for (genvar l = 0; l < PAR_QR; l++) begin : g_lane
        logic [3:0][31:0] qx, qy;
        always_comb begin
            qx = '0;
            for (int k = 0; k < 4; k++) qx[k] = work[idx[l][k]];
        end
        chacha_qr u_qr (.x(qx), .y(qy));
        assign qy_all[l] = qy;
    end

    // Lanes in one cycle touch disjoint words, so write-back order is free.
    always_comb begin
        work_n = work;
        for (int l = 0; l < PAR_QR; l++)
            for (int k = 0; k < 4; k++)
                work_n[idx[l][k]] = qy_all[l][k];
    end

    always_comb begin
        for (int i = 0; i < 16; i++)
            result[i] = (FEEDFORWARD != 0) ? work_n[i] + save[i] : work_n[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            work    <= '0;
            save    <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    work <= bus.in_state;
                    save <= bus.in_state;
                    cnt  <= '0;
                end
                RUN: begin
                    work <= work_n;
                    if (last) begin
                        cnt     <= '0;
                        out_reg <= result;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_state = out_reg;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 block vector on several
// configurations, all-zero state, backpressure, mid-run reset, back-to-back.
module tb_chacha_block_core;
    localparam logic [511:0] RFC_IN = {
        32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
        32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    localparam logic [511:0] RFC_FF = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    localparam logic [511:0] RFC_RAW = {
        32'h4e3c50a2, 32'h9e83d0cb, 32'hb04e16de, 32'hd19c12b4,
        32'h82e46ebd, 32'heabda8fc, 32'hf29489f3, 32'h335271c2,
        32'h3f5ec7b7, 32'h8fa018fc, 32'hfc62bb2f, 32'hc4f2d0c7,
        32'h5950bb2f, 32'ha67ae21e, 32'he238d763, 32'h837778ab};

    logic         clk, rst, in_valid, out_ready;
    logic [511:0] in_state;
    logic [1:0]   sel;
    logic         o_ready, o_valid, o_busy;
    logic [511:0] o_state;
    int           n_pass, n_total, ecnt;
    int           acc_q[$];
    logic [511:0] res_q[$];

    chacha_block_core_if bus0 ();
    chacha_block_core_if bus1 ();
    chacha_block_core_if bus2 ();
    chacha_block_core_if bus3 ();

    assign bus0.in_valid = in_valid && (sel == 2'd0);
    assign bus1.in_valid = in_valid && (sel == 2'd1);
    assign bus2.in_valid = in_valid && (sel == 2'd2);
    assign bus3.in_valid = in_valid && (sel == 2'd3);
    assign bus0.in_state = in_state;
    assign bus1.in_state = in_state;
    assign bus2.in_state = in_state;
    assign bus3.in_state = in_state;
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;
    assign bus2.out_ready = out_ready;
    assign bus3.out_ready = out_ready;

    chacha_block_core #(.ROUNDS(20), .PAR_QR(4), .FEEDFORWARD(1)) u_p4 (.clk(clk), .rst(rst), .bus(bus0));
    chacha_block_core #(.ROUNDS(20), .PAR_QR(1), .FEEDFORWARD(1)) u_p1 (.clk(clk), .rst(rst), .bus(bus1));
    chacha_block_core #(.ROUNDS(20), .PAR_QR(2), .FEEDFORWARD(1)) u_p2 (.clk(clk), .rst(rst), .bus(bus2));
    chacha_block_core #(.ROUNDS(20), .PAR_QR(4), .FEEDFORWARD(0)) u_nf (.clk(clk), .rst(rst), .bus(bus3));

    always_comb begin
        case (sel)
            2'd1:    begin o_ready = bus1.in_ready; o_valid = bus1.out_valid; o_busy = bus1.busy; o_state = bus1.out_state; end
            2'd2:    begin o_ready = bus2.in_ready; o_valid = bus2.out_valid; o_busy = bus2.busy; o_state = bus2.out_state; end
            2'd3:    begin o_ready = bus3.in_ready; o_valid = bus3.out_valid; o_busy = bus3.busy; o_state = bus3.out_state; end
            default: begin o_ready = bus0.in_ready; o_valid = bus0.out_valid; o_busy = bus0.busy; o_state = bus0.out_state; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ecnt = 0;
    always @(posedge clk) ecnt = ecnt + 1;

    // Handshakes are sampled mid-cycle; the recorded edge index is the same
    // for every entry so differences give edge distances.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && o_ready) acc_q.push_back(ecnt);
            if (o_valid && out_ready) res_q.push_back(o_state);
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Single block with out_ready high; lat = edges from accept edge to the
    // edge where out_valid is first high (the handshake edge).
    task automatic run_block(input logic [511:0] s, output int lat, output logic [511:0] res);
        logic ov;
        @(negedge clk);
        in_state = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; res = '1;
        do begin
            @(negedge clk);
            ov = o_valid;
            if (ov) res = o_state;
            @(posedge clk);
            lat++;
        end while (!ov && lat < 400);
    endtask

    // Zero state with in_valid held high the whole time; bad counts cycles
    // where the core was busy yet advertised in_ready.
    task automatic zero_hold(output int bad, output logic [511:0] res);
        logic ov;
        int   n;
        @(negedge clk);
        in_state = '0; in_valid = 1'b1; out_ready = 1'b1;
        bad = 0; n = 0; res = '1;
        @(posedge clk);
        do begin
            @(negedge clk);
            if (o_busy && o_ready) bad++;
            if (!o_busy) bad++;
            ov = o_valid;
            if (ov) res = o_state;
            @(posedge clk);
            n++;
        end while (!ov && n < 400);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int           lat, bad, n;
        logic [511:0] res;
        n_pass = 0; n_total = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", o_valid, 1'b0);
        chk("reset_in_ready",  o_ready, 1'b1);
        chk("reset_busy",      o_busy,  1'b0);
        chk("reset_out_state", o_state, '0);

        // RFC vector, default configuration
        run_block(RFC_IN, lat, res);
        chk("rfc_p4_words0_3", res[127:0], RFC_FF[127:0]);
        chk("rfc_p4_state",    res, RFC_FF);
        chk("rfc_p4_latency",  lat, 21);
        @(negedge clk);
        chk("rfc_p4_ready_after", o_ready, 1'b1);

        sel = 2'd1;
        run_block(RFC_IN, lat, res);
        chk("rfc_p1_state",   res, RFC_FF);
        chk("rfc_p1_latency", lat, 81);

        sel = 2'd2;
        run_block(RFC_IN, lat, res);
        chk("rfc_p2_state",   res, RFC_FF);
        chk("rfc_p2_latency", lat, 41);

        sel = 2'd3;
        run_block(RFC_IN, lat, res);
        chk("rfc_noff_state",   res, RFC_RAW);
        chk("rfc_noff_latency", lat, 21);

        // all-zero state is a fixed point with and without feed-forward
        sel = 2'd0;
        zero_hold(bad, res);
        chk("zero_ff_state",  res, '0);
        chk("zero_ff_ready",  bad, 0);
        sel = 2'd3;
        zero_hold(bad, res);
        chk("zero_noff_state", res, '0);
        chk("zero_noff_ready", bad, 0);

        // backpressure
        sel = 2'd0;
        @(negedge clk);
        in_state = RFC_IN; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_state = '0;           // keep in_valid high with another state
        n = 0;
        do begin @(negedge clk); n++; end while (!o_valid && n < 200);
        chk("bp_valid_seen", o_valid, 1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_state !== RFC_FF || o_busy !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        chk("bp_state", o_state, RFC_FF);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after",  o_ready, 1'b1);
        chk("bp_valid_after",  o_valid, 1'b0);
        chk("bp_busy_after",   o_busy,  1'b0);

        // reset mid-RUN: rst high on the 5th edge after accept
        res_q.delete();
        in_state = RFC_IN; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", o_valid, 1'b0);
        chk("abort_in_ready",  o_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) bad++;
        end
        chk("abort_no_output", bad, 0);
        chk("abort_no_result_count", res_q.size(), 0);
        run_block(RFC_IN, lat, res);
        chk("abort_next_state",   res, RFC_FF);
        chk("abort_next_latency", lat, 21);

        // back-to-back with in_valid and out_ready held high
        @(negedge clk);
        acc_q.delete(); res_q.delete();
        in_state = RFC_IN; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_state = '0;
        n = 0;
        do begin @(posedge clk); #1 n++; end while (res_q.size() < 2 && n < 200);
        in_valid = 1'b0;
        chk("b2b_accept_count", acc_q.size(), 2);
        chk("b2b_result_count", res_q.size(), 2);
        if (acc_q.size() >= 2) chk("b2b_accept_spacing", acc_q[1] - acc_q[0], 22);
        if (res_q.size() >= 2) begin
            chk("b2b_first",  res_q[0], RFC_FF);
            chk("b2b_second", res_q[1], '0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/chacha_block_core.md
Name: chacha_block_core

Overview:
- Sequential ChaCha block-function engine: accepts a 512-bit state, applies ROUNDS rounds of quarter-rounds by iterating, then optionally adds the input state and presents the 512-bit result.
- Parametrised successor of the combinational quarter-round: generalised in round count and in how many quarter-rounds run per clock (area/throughput trade).
- Sits between the state-assembly logic (key/counter/nonce packing) and the keystream XOR stage, with valid/ready on both sides.

Parameters:
- ROUNDS, 20, total rounds; must be even and >= 2 (8/12/20 are the supported variants). Any other value is an elaboration error.
- PAR_QR, 4, quarter-round instances evaluated per cycle; legal values 1, 2, 4. Any other value is an elaboration error.
- FEEDFORWARD, 1, when 1 the output is the final state plus the input state word-wise mod 2^32; when 0 the output is the raw permuted state.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  core can accept a new state
- in_state  input  512  word i = bits [32i+31:32i], i = 0..15
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  512  result, same word layout as in_state
- busy  output  1  high while in RUN or DONE

Behaviour:
- Reset is synchronous: on rst=1 at a clock edge, FSM goes to IDLE, out_valid=0, in_ready=1 (from the next cycle), busy=0, out_state=0, counters=0. An in-flight block is discarded. A handshake on the same edge as rst is ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready: latch in_state into the working register and the save register, clear counters, go to RUN.
- RUN:
  - Each cycle, apply PAR_QR quarter-rounds to the working state.
  - Each half-round is 4 QRs, taken in ascending group order.
  - Column half-round groups: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
  - Diagonal half-round groups: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  - Half-rounds alternate column, diagonal, column, ..., starting with column.
  - PAR_QR=4: one half-round per cycle. PAR_QR=2: groups {0,1} then {2,3}. PAR_QR=1: one group per cycle.
  - Quarter-round (a,b,c,d), all arithmetic 32-bit mod 2^32, rotate-left:
    - a+=b; d^=a; d<<<=16
    - c+=d; b^=c; b<<<=12
    - a+=b; d^=a; d<<<=8
    - c+=d; b^=c; b<<<=7
  - RUN lasts exactly N = ROUNDS*4/PAR_QR cycles. After the Nth update, go to DONE.
  - out_state is registered on that transition: working + save if FEEDFORWARD=1, otherwise working.
- DONE:
  - out_valid=1, out_state stable until handshake.
  - On out_valid&out_ready: out_valid drops next cycle, go to IDLE.
  - out_ready may be held low indefinitely; nothing changes while it is low.
- Latency: accept edge to out_valid high = N+1 cycles (20 +1=21 for defaults; 81 for PAR_QR=1).
- Throughput: one block per N+2 cycles with out_ready tied high. No acceptance overlaps DONE.
- in_ready=0 in RUN and DONE. in_valid asserted then is not consumed, and upstream must hold it.
- out_valid never asserts without a preceding accepted input since reset.
- The half-round counter wraps only on FSM exit. Counter width is ceil(log2(N+1)).

Test Plan:
- RFC 8439 §2.3.2 block (key 00..1f, counter 1, nonce 000000090000004a00000000), defaults:
  - Required: out_state words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; full 16 words match the RFC.
  - Required: out_valid exactly 21 cycles after the accept edge.
- Same vector at PAR_QR=1 and PAR_QR=2:
  - Required: identical out_state.
  - Required: out_valid at 81 and 41 cycles after accept respectively.
- All-zero in_state, FEEDFORWARD=1 and FEEDFORWARD=0:
  - Required: out_state all zero in both cases.
  - Required: in_ready=0 throughout RUN/DONE despite in_valid held high.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid rises.
  - Required: out_state unchanged, busy=1, in_ready=0.
  - Required: after out_ready=1, handshake on that edge, then in_ready=1 next cycle.
- Reset mid-RUN (rst pulsed 5 cycles after accept):
  - Required: out_valid=0 and in_ready=1 the cycle after rst; no output ever appears for the aborted block.
  - Required: a following RFC vector block produces the correct result.
- Back-to-back with out_ready tied 1 and in_valid tied 1, two different states:
  - Required: second accept occurs exactly N+2 cycles after the first.
  - Required: both results correct and in order.
